// File: rtl/qam16_mapper.sv
// 16-QAM Gray mapper with input symbol FIFO and zero-inserting upsampler.
// Symbols are pushed through a valid/ready handshake. One symbol is popped at
// each phase-0 slot, mapped to signed I/Q levels, and followed by OSR-1 zero
// samples.
module qam16_mapper #(
  parameter int OSR        = 8,
  parameter int OUT_W      = 8,
  parameter int LEVEL      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [3:0]                      sym_in,
  input  logic                            sym_valid,
  output logic                            sym_ready,
  output logic signed [OUT_W-1:0]         i_out,
  output logic signed [OUT_W-1:0]         q_out,
  output logic                            out_valid,
  output logic                            sym_strobe,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(OSR);

  localparam logic [AW:0]               FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]               CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]             PTR_ONE  = AW'(1);
  localparam logic [PW-1:0]             PH_LAST  = PW'(OSR - 1);
  localparam logic [PW-1:0]             PH_ONE   = PW'(1);
  localparam logic signed [OUT_W-1:0]   LVL1     = OUT_W'(LEVEL);
  localparam logic signed [OUT_W-1:0]   LVL3     = OUT_W'(3 * LEVEL);

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [PW-1:0] phase;
  logic          push;
  logic          pop;
  logic          slot;
  logic [3:0]    head;

  // Gray mapping for a single axis.
  function automatic logic signed [OUT_W-1:0] gray_map(input logic [1:0] b);
    logic signed [OUT_W-1:0] v;
    case (b)
      2'b00:   v = -LVL3;
      2'b01:   v = -LVL1;
      2'b11:   v = LVL1;
      default: v = LVL3;
    endcase
    return v;
  endfunction

  assign sym_ready  = (count != FULL_CNT);
  assign fifo_level = count;
  assign head       = mem[rd_ptr];

  // Handshake and slot decode; the pop only looks at the registered count,
  // so a symbol pushed on the same edge cannot be popped on that edge.
  always_comb begin
    slot = start && (phase == '0);
    push = sym_valid && sym_ready;
    pop  = slot && (count != '0);
  end

  // Symbol storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sym_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sample phase within a symbol; held at 0 while stopped so a restart begins a new slot.
  always_ff @(posedge clk) begin
    if (rst || !start)        phase <= '0;
    else if (phase == PH_LAST) phase <= '0;
    else                      phase <= phase + PH_ONE;
  end

  // Registered sample outputs and the sticky underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_out      <= '0;
      q_out      <= '0;
      out_valid  <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      out_valid  <= start;
      i_out      <= '0;
      q_out      <= '0;
      sym_strobe <= 1'b0;
      if (pop) begin
        i_out      <= gray_map(head[3:2]);
        q_out      <= gray_map(head[1:0]);
        sym_strobe <= 1'b1;
      end else if (slot) begin
        underrun   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qam16_mapper.sv
// Randomized self-checking bench for qam16_mapper against a queue-based model.
module tb_qam16_mapper;

  localparam int OSR   = 4;
  localparam int OUT_W = 8;
  localparam int LEVEL = 32;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [3:0]              sym_in;
  logic                    sym_valid;
  logic                    sym_ready;
  logic signed [OUT_W-1:0] i_out;
  logic signed [OUT_W-1:0] q_out;
  logic                    out_valid;
  logic                    sym_strobe;
  logic                    underrun;
  logic [2:0]              fifo_level;

  always #5 clk = ~clk;

  qam16_mapper #(
    .OSR(OSR),
    .OUT_W(OUT_W),
    .LEVEL(LEVEL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sym_in(sym_in),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .i_out(i_out),
    .q_out(q_out),
    .out_valid(out_valid),
    .sym_strobe(sym_strobe),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: symbol queue, phase count, expected outputs.
  logic [3:0] mq[$];
  int m_phase = 0;
  int e_i = 0, e_q = 0, e_valid = 0, e_strobe = 0, e_under = 0;

  function automatic int level_of(input logic [1:0] b);
    case (b)
      2'b00:   return -3 * LEVEL;
      2'b01:   return -LEVEL;
      2'b11:   return LEVEL;
      default: return 3 * LEVEL;
    endcase
  endfunction

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic cycle(input logic r, input logic s, input logic v,
                       input logic [3:0] d, output logic accepted);
    logic [3:0] sym;
    bit room;
    rst = r; start = s; sym_valid = v; sym_in = d;
    room = (mq.size() < DEPTH);
    accepted = v && room && !r;
    if (r) begin
      mq.delete();
      m_phase = 0;
      e_i = 0; e_q = 0; e_valid = 0; e_strobe = 0; e_under = 0;
    end else begin
      e_i = 0; e_q = 0; e_strobe = 0;
      if (s) begin
        e_valid = 1;
        if (m_phase == 0) begin
          if (mq.size() > 0) begin
            sym = mq.pop_front();
            e_i = level_of(sym[3:2]);
            e_q = level_of(sym[1:0]);
            e_strobe = 1;
          end else begin
            e_under = 1;
          end
        end
        m_phase = (m_phase + 1) % OSR;
      end else begin
        e_valid = 0;
        m_phase = 0;
      end
      if (accepted) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    check("i_out", i_out, e_i);
    check("q_out", q_out, e_q);
    check("out_valid", out_valid, e_valid);
    check("sym_strobe", sym_strobe, e_strobe);
    check("underrun", underrun, e_under);
    check("fifo_level", fifo_level, mq.size());
    check("sym_ready", sym_ready, (mq.size() < DEPTH) ? 1 : 0);
  endtask

  initial begin
    logic acc;
    logic [3:0] pend;
    bit have;
    int idx;
    int gap;

    rst = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_in = '0;
    cycle(1, 0, 0, 4'h0, acc);
    cycle(1, 0, 0, 4'h0, acc);

    // All 16 symbols in order through the handshake with start running.
    idx = 0;
    for (int c = 0; c < 90; c++) begin
      cycle(0, 1, idx < 16, 4'(idx), acc);
      if (acc) idx++;
    end

    // Latency: one preloaded symbol, then start.
    cycle(1, 0, 0, 4'h0, acc);
    cycle(0, 0, 1, 4'b1001, acc);
    for (int c = 0; c < 2 * OSR + 2; c++) cycle(0, 1, 0, 4'h0, acc);

    // Backpressure: five symbols with start low, then release.
    cycle(1, 0, 0, 4'h0, acc);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(0, 0, idx < 5, 4'(4'hA + idx), acc);
      if (acc) idx++;
    end
    for (int c = 0; c < 30; c++) begin
      cycle(0, 1, idx < 5, 4'(4'hA + idx), acc);
      if (acc) idx++;
    end

    // Underrun on an empty FIFO, then a late push.
    cycle(1, 0, 0, 4'h0, acc);
    for (int c = 0; c < 9; c++) cycle(0, 1, 0, 4'h0, acc);
    cycle(0, 1, 1, 4'b0011, acc);
    for (int c = 0; c < 2 * OSR; c++) cycle(0, 1, 0, 4'h0, acc);

    // Start toggle mid-symbol and reset mid-symbol with a loaded FIFO.
    for (int c = 0; c < 4; c++) cycle(0, 0, 1, 4'(c + 5), acc);
    for (int c = 0; c < 3; c++) cycle(0, 1, 0, 4'h0, acc);
    for (int c = 0; c < 5; c++) cycle(0, 0, 0, 4'h0, acc);
    for (int c = 0; c < 2; c++) cycle(0, 1, 0, 4'h0, acc);
    cycle(1, 1, 0, 4'h0, acc);
    for (int c = 0; c < 3 * OSR; c++) cycle(0, 1, 0, 4'h0, acc);

    // Randomized traffic from a conforming source that holds data until accepted.
    have = 0;
    pend = '0;
    gap  = 0;
    for (int c = 0; c < 2000; c++) begin
      logic r, s, v;
      if (!have && $urandom_range(0, 2) != 0) begin
        pend = 4'($urandom);
        have = 1;
      end
      if (gap > 0) gap--;
      else if ($urandom_range(0, 24) == 0) gap = $urandom_range(1, 7);
      r = ($urandom_range(0, 149) == 0);
      s = (gap == 0);
      v = have;
      cycle(r, s, v, pend, acc);
      if (acc) have = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
